// File: rtl/vote_tally_ctrl.sv
// Ballot tally controller: arms on Ballot, records one selection per
// authorisation, then scans per-candidate tallies to find the winner.
module vote_tally_ctrl #(
   parameter int N_CAND = 15,
   parameter int CW     = 12,
   parameter int IW     = 4
) (
   input  logic          clk,
   input  logic          Power,
   input  logic          Clear,
   input  logic          Close,
   input  logic          Ballot,
   input  logic          Total,
   input  logic          Result,
   input  logic [IW-1:0] IN,
   output logic [CW-1:0] out,
   output logic          out_valid,
   output logic [IW-1:0] out_idx,
   output logic [IW-1:0] winner,
   output logic          tie,
   output logic          done,
   output logic [CW-1:0] invalid_cnt
);

   typedef enum logic [2:0] {OPEN, ARMED, CLOSED, SCAN, DONE} state_t;

   localparam logic [IW-1:0] NC   = IW'(N_CAND);
   localparam logic [CW-1:0] CMAX = '1;

   state_t                   state, state_nx;
   logic [N_CAND:1][CW-1:0]  tally;
   logic [CW-1:0]            total, max_q, cur_tally, win_tally;
   logic [IW-1:0]            idx_q;
   logic                     res_prev, show_tot, tie_q;
   logic                     vote, bad, scan_start, tot_nx, res_rise;

   assign res_rise = Result & ~res_prev;

   always_comb begin
      state_nx   = state;
      vote       = 1'b0;
      bad        = 1'b0;
      scan_start = 1'b0;
      tot_nx     = 1'b0;
      if (Clear) begin
         state_nx = OPEN;
      end else begin
         case (state)
            OPEN: begin
               if (Close)       state_nx = CLOSED;
               else if (Ballot) state_nx = ARMED;
               else             tot_nx   = Total;
            end
            ARMED: begin
               if (Close) begin
                  state_nx = CLOSED;
               end else if (IN != '0 && IN <= NC) begin
                  vote     = 1'b1;
                  state_nx = OPEN;
               end else if (IN > NC) begin
                  bad      = 1'b1;
                  state_nx = OPEN;
               end
            end
            CLOSED, DONE: begin
               if (res_rise) begin
                  scan_start = 1'b1;
                  state_nx   = SCAN;
               end
            end
            SCAN: begin
               if (idx_q == NC) state_nx = DONE;
            end
            default: state_nx = OPEN;
         endcase
      end
   end

   // One saturating counter per candidate.
   for (genvar i = 1; i <= N_CAND; i++) begin : g_cand
      logic [CW-1:0] cnt;
      always_ff @(posedge clk) begin
         if (Power || Clear)
            cnt <= '0;
         else if (vote && IN == IW'(i) && cnt != CMAX)
            cnt <= cnt + 1'b1;
      end
      assign tally[i] = cnt;
   end

   always_ff @(posedge clk) begin
      if (Power || Clear) begin
         total       <= '0;
         invalid_cnt <= '0;
      end else begin
         if (vote && total != CMAX)       total       <= total + 1'b1;
         if (bad && invalid_cnt != CMAX)  invalid_cnt <= invalid_cnt + 1'b1;
      end
   end

   always_comb begin
      cur_tally = '0;
      win_tally = '0;
      for (int i = 1; i <= N_CAND; i++) begin
         if (idx_q == IW'(i))  cur_tally = tally[i];
         if (winner == IW'(i)) win_tally = tally[i];
      end
   end

   always_ff @(posedge clk) begin
      if (Power) begin
         state    <= OPEN;
         idx_q    <= '0;
         max_q    <= '0;
         winner   <= '0;
         tie_q    <= 1'b0;
         res_prev <= 1'b0;
         show_tot <= 1'b0;
      end else begin
         state    <= state_nx;
         res_prev <= Result;
         show_tot <= tot_nx;
         if (Clear) begin
            idx_q  <= '0;
            max_q  <= '0;
            winner <= '0;
            tie_q  <= 1'b0;
         end else if (scan_start) begin
            idx_q <= IW'(1);
         end else if (state == SCAN) begin
            idx_q <= idx_q + 1'b1;
            // First candidate seeds the running max; later ones only win on strictly greater.
            if (idx_q == IW'(1) || cur_tally > max_q) begin
               winner <= idx_q;
               max_q  <= cur_tally;
               tie_q  <= 1'b0;
            end else if (cur_tally == max_q) begin
               tie_q <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      out       = '0;
      out_valid = 1'b0;
      out_idx   = '0;
      done      = 1'b0;
      case (state)
         OPEN: begin
            if (show_tot) begin
               out       = total;
               out_valid = 1'b1;
            end
         end
         CLOSED: begin
            out       = total;
            out_valid = 1'b1;
         end
         SCAN: begin
            out       = cur_tally;
            out_idx   = idx_q;
            out_valid = 1'b1;
         end
         DONE: begin
            out       = win_tally;
            out_idx   = winner;
            out_valid = 1'b1;
            done      = 1'b1;
         end
         default: ;
      endcase
   end

   assign tie = tie_q & done;

endmodule

// File: tb/tb_vote_tally_ctrl.sv
// Bench for vote_tally_ctrl: directed scenarios plus random traffic, checked
// every cycle against a ballot-level model of the default build.
module tb_vote_tally_ctrl;

   localparam int NC   = 15;
   localparam int CMAX = 4095;

   logic       clk = 1'b0;
   logic       Power = 1'b1, Clear = 1'b0, Close = 1'b0, Ballot = 1'b0;
   logic       Total = 1'b0, Result = 1'b0;
   logic [3:0] IN = '0;

   logic [11:0] d0_out, d0_inv;
   logic        d0_vld, d0_tie, d0_done;
   logic [3:0]  d0_idx, d0_win;

   logic [11:0] d1_out, d1_inv;
   logic        d1_vld, d1_tie, d1_done;
   logic [3:0]  d1_idx, d1_win;

   logic [3:0]  d2_out, d2_inv;
   logic        d2_vld, d2_tie, d2_done;
   logic [3:0]  d2_idx, d2_win;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vote_tally_ctrl dut0 (
      .clk(clk), .Power(Power), .Clear(Clear), .Close(Close), .Ballot(Ballot),
      .Total(Total), .Result(Result), .IN(IN), .out(d0_out), .out_valid(d0_vld),
      .out_idx(d0_idx), .winner(d0_win), .tie(d0_tie), .done(d0_done),
      .invalid_cnt(d0_inv));

   vote_tally_ctrl #(.N_CAND(10)) dut1 (
      .clk(clk), .Power(Power), .Clear(Clear), .Close(Close), .Ballot(Ballot),
      .Total(Total), .Result(Result), .IN(IN), .out(d1_out), .out_valid(d1_vld),
      .out_idx(d1_idx), .winner(d1_win), .tie(d1_tie), .done(d1_done),
      .invalid_cnt(d1_inv));

   vote_tally_ctrl #(.CW(4)) dut2 (
      .clk(clk), .Power(Power), .Clear(Clear), .Close(Close), .Ballot(Ballot),
      .Total(Total), .Result(Result), .IN(IN), .out(d2_out), .out_valid(d2_vld),
      .out_idx(d2_idx), .winner(d2_win), .tie(d2_tie), .done(d2_done),
      .invalid_cnt(d2_inv));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Ballot-level model of dut0
   typedef enum {M_OPEN, M_ARMED, M_CLOSED, M_SCAN, M_DONE} mode_t;
   mode_t m_mode = M_OPEN;
   int    m_tally [1:NC];
   int    m_total = 0, m_inv = 0, m_win = 0, m_pos = 0;
   bit    m_tie = 0, m_show = 0, m_prev = 0, m_ok = 0;
   int    e_out, e_idx;
   bit    e_vld, e_done;

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   always @(posedge clk) begin
      bit rise;
      int best, nbest;
      rise = Result && !m_prev;
      if (Power) begin
         m_ok = 1; m_mode = M_OPEN; m_show = 0; m_prev = 0;
         m_total = 0; m_inv = 0; m_win = 0; m_tie = 0; m_pos = 0;
         for (int i = 1; i <= NC; i++) m_tally[i] = 0;
      end else begin
         m_prev = Result;
         m_show = 0;
         if (Clear) begin
            m_mode = M_OPEN; m_total = 0; m_inv = 0; m_win = 0; m_tie = 0;
            for (int i = 1; i <= NC; i++) m_tally[i] = 0;
         end else begin
            case (m_mode)
               M_OPEN:
                  if (Close) m_mode = M_CLOSED;
                  else if (Ballot) m_mode = M_ARMED;
                  else m_show = Total;
               M_ARMED:
                  if (Close) m_mode = M_CLOSED;
                  else if (IN >= 1 && int'(IN) <= NC) begin
                     m_tally[IN] = sat(m_tally[IN]);
                     m_total = sat(m_total);
                     m_mode = M_OPEN;
                  end else if (int'(IN) > NC) begin
                     m_inv = sat(m_inv);
                     m_mode = M_OPEN;
                  end
               M_CLOSED, M_DONE:
                  if (rise) begin
                     best = -1; nbest = 0;
                     for (int i = 1; i <= NC; i++) if (m_tally[i] > best) begin
                        best = m_tally[i]; m_win = i;
                     end
                     for (int i = 1; i <= NC; i++) if (m_tally[i] == best) nbest++;
                     m_tie = (nbest > 1);
                     m_pos = 1;
                     m_mode = M_SCAN;
                  end
               M_SCAN:
                  if (m_pos == NC) m_mode = M_DONE;
                  else m_pos++;
               default: ;
            endcase
         end
      end
      e_out = 0; e_vld = 0; e_idx = 0; e_done = 0;
      case (m_mode)
         M_OPEN:   if (m_show) begin e_out = m_total; e_vld = 1; end
         M_CLOSED: begin e_out = m_total; e_vld = 1; end
         M_SCAN:   begin e_out = m_tally[m_pos]; e_idx = m_pos; e_vld = 1; end
         M_DONE:   begin e_out = m_tally[m_win]; e_idx = m_win; e_vld = 1; e_done = 1; end
         default: ;
      endcase
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("out", int'(d0_out), e_out);
         chk("out_valid", int'(d0_vld), int'(e_vld));
         chk("out_idx", int'(d0_idx), e_idx);
         chk("done", int'(d0_done), int'(e_done));
         chk("tie", int'(d0_tie), e_done ? int'(m_tie) : 0);
         chk("invalid_cnt", int'(d0_inv), m_inv);
         if (e_done) chk("winner", int'(d0_win), m_win);
      end
   end

   task automatic cyc(input bit pw, cl, cs, bl, tt, rs, input int in_v);
      Power = pw; Clear = cl; Close = cs; Ballot = bl; Total = tt; Result = rs;
      IN = 4'(in_v);
      @(posedge clk);
      #1;
   endtask

   task automatic vote(input int v);
      cyc(0, 0, 0, 1, 0, 0, v);
      cyc(0, 0, 0, 0, 0, 0, v);
   endtask

   task automatic run_scan();
      cyc(0, 0, 0, 0, 0, 1, 0);
      repeat (15) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int exp36 [1:15];
      exp36 = '{0, 0, 5, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0};
      #1;
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("rst_out", int'(d0_out), 0);
      chk("rst_valid", int'(d0_vld), 0);
      chk("rst_winner", int'(d0_win), 0);
      chk("rst_done", int'(d0_done), 0);
      chk("rst_inv", int'(d0_inv), 0);

      // Five votes for 3, two for 7, then scan.
      cyc(0, 0, 0, 0, 0, 0, 0);
      repeat (5) vote(3);
      repeat (2) vote(7);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("total_7", int'(d0_out), 7);
      chk("total_7_valid", int'(d0_vld), 1);
      cyc(0, 0, 1, 0, 0, 0, 0);
      chk("closed_total", int'(d0_out), 7);
      cyc(0, 0, 1, 0, 0, 1, 0);
      for (int k = 1; k <= 15; k++) begin
         chk("scan_idx", int'(d0_idx), k);
         chk("scan_out", int'(d0_out), exp36[k]);
         if (k < 15) cyc(0, 0, 1, 0, 0, 1, 0);
      end
      cyc(0, 0, 1, 0, 0, 1, 0);
      chk("win3", int'(d0_win), 3);
      chk("win3_tie", int'(d0_tie), 0);
      chk("win3_done", int'(d0_done), 1);
      chk("win3_out", int'(d0_out), 5);
      repeat (3) cyc(0, 0, 1, 0, 0, 1, 0);
      chk("held_no_rescan", int'(d0_done), 1);

      // Tie between 2 and 9, lowest index wins.
      cyc(0, 1, 0, 0, 0, 0, 0);
      repeat (4) vote(2);
      repeat (4) vote(9);
      cyc(0, 0, 1, 0, 0, 0, 0);
      run_scan();
      chk("tie_win", int'(d0_win), 2);
      chk("tie_flag", int'(d0_tie), 1);
      chk("tie_out", int'(d0_out), 4);

      // Armed with no selection, then closed: ballot voided.
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      repeat (10) cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      chk("void_total", int'(d0_out), 0);
      chk("void_closed_valid", int'(d0_vld), 1);
      chk("void_done", int'(d0_done), 0);

      // Out-of-range on the 10-candidate build, saturation on the 4-bit build.
      cyc(0, 1, 0, 0, 0, 0, 0);
      vote(12);
      chk("n10_invalid", int'(d1_inv), 1);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("n10_total", int'(d1_out), 0);
      chk("n15_total", int'(d0_out), 1);
      vote(15);
      repeat (20) vote(1);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("cw4_total_sat", int'(d2_out), 15);
      chk("n15_total22", int'(d0_out), 22);
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      chk("cw4_tally1_sat", int'(d2_out), 15);
      repeat (15) cyc(0, 0, 0, 0, 0, 0, 0);
      chk("n15_win1", int'(d0_win), 1);

      // Clear mid-scan at idx 6.
      cyc(0, 1, 0, 0, 0, 0, 0);
      repeat (2) vote(6);
      vote(3);
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      repeat (5) cyc(0, 0, 0, 0, 0, 0, 0);
      chk("scan_at6", int'(d0_idx), 6);
      chk("scan_at6_out", int'(d0_out), 2);
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("clr_out", int'(d0_out), 0);
      chk("clr_valid", int'(d0_vld), 0);
      chk("clr_done", int'(d0_done), 0);
      chk("clr_winner", int'(d0_win), 0);
      vote(4);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("after_clr_total", int'(d0_out), 1);

      // Power while armed and mid-scan.
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 5);
      cyc(0, 0, 0, 0, 1, 0, 5);
      chk("pwr_armed_total", int'(d0_out), 0);
      vote(5);
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("pwr_scan_valid", int'(d0_vld), 0);
      cyc(0, 0, 0, 0, 0, 0, 0);

      for (int n = 0; n < 3000; n++) begin
         cyc($urandom_range(199) == 0, $urandom_range(99) == 0,
             $urandom_range(29) == 0, $urandom_range(2) == 0,
             $urandom_range(3) == 0, $urandom_range(5) == 0,
             ($urandom_range(3) == 0) ? 0 : int'($urandom_range(15)));
      end
      cyc(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
